// File: rtl/instr_encoder_if.sv
// Request/response bundle for the instruction encoder: request fields in,
// encoded FIFO head out, plus the two running counters.
interface instr_encoder_if;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [63:0] in_imm;
   logic [4:0]  in_rt;
   logic [4:0]  in_rn;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic        out_err;
   logic [15:0] err_count;
   logic [15:0] enc_count;

   // Both sides use valid/ready: a beat transfers on a rising clk edge where
   // valid and ready are both 1; valid holds with stable data until it does.
   modport master (
      output in_valid, in_fmt, in_imm, in_rt, in_rn, out_ready,
      input  in_ready, out_valid, out_instr, out_err, err_count, enc_count
   );

   modport slave (
      input  in_valid, in_fmt, in_imm, in_rt, in_rn, out_ready,
      output in_ready, out_valid, out_instr, out_err, err_count, enc_count
   );
endinterface

// File: rtl/instr_encoder.sv
// ARMv8 LDUR/STUR/CBZ/CBNZ/ADDI/SUBI field encoder with range checking,
// feeding a DEPTH-entry output FIFO and error/encode counters.
module instr_encoder #(
   parameter int DEPTH = 2
) (
   input logic             clk,
   input logic             reset,
   instr_encoder_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   enc_instr;
   logic          enc_err;
   logic          fits_d;
   logic          fits_cb;
   logic          fits_i;

   logic [32:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          started;
   logic          push;
   logic          pop;

   // Sign-extension checks: upper bits all equal means the value fits the field.
   assign fits_d  = (&bus.in_imm[63:8])  | ~(|bus.in_imm[63:8]);
   assign fits_cb = ((&bus.in_imm[63:20]) | ~(|bus.in_imm[63:20])) & (bus.in_imm[1:0] == 2'b00);
   assign fits_i  = ~(|bus.in_imm[63:12]);

   always_comb begin
      enc_instr = 32'h0;
      enc_err   = 1'b1;
      case (bus.in_fmt)
         3'b000, 3'b001: begin
            enc_err   = ~fits_d;
            enc_instr = {(bus.in_fmt[0] ? 11'b11111000000 : 11'b11111000010),
                         bus.in_imm[8:0], 2'b00, bus.in_rn, bus.in_rt};
         end
         3'b010, 3'b011: begin
            enc_err   = ~fits_cb;
            enc_instr = {(bus.in_fmt[0] ? 8'b10110101 : 8'b10110100),
                         bus.in_imm[20:2], bus.in_rt};
         end
         3'b100, 3'b101: begin
            enc_err   = ~fits_i;
            enc_instr = {(bus.in_fmt[0] ? 10'b1101000100 : 10'b1001000100),
                         bus.in_imm[11:0], bus.in_rn, bus.in_rt};
         end
         default: begin
            enc_err   = 1'b1;
            enc_instr = 32'h0;
         end
      endcase
      if (enc_err) enc_instr = 32'h0;
   end

   // in_ready is registered state only, so it never follows out_ready.
   assign bus.in_ready  = started & (count != CW'(DEPTH));
   assign bus.out_valid = (count != '0);
   assign push          = bus.in_valid & bus.in_ready;
   assign pop           = bus.out_valid & bus.out_ready;
   assign bus.out_instr = bus.out_valid ? mem[rd_ptr][31:0] : 32'h0;
   assign bus.out_err   = bus.out_valid & mem[rd_ptr][32];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {enc_err, enc_instr};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         started <= 1'b0;
      end else begin
         started <= 1'b1;
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.err_count <= 16'h0;
         bus.enc_count <= 16'h0;
      end else if (push) begin
         if (enc_err) begin
            if (bus.err_count != 16'hFFFF) bus.err_count <= bus.err_count + 16'h1;
         end else begin
            bus.enc_count <= bus.enc_count + 16'h1;
         end
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed encodings, full/empty
// boundaries, mid-run reset and a random sweep with field decode-back.
module tb_instr_encoder;
   localparam int DEPTH = 2;

   logic clk;
   logic reset;
   instr_encoder_if bus();

   instr_encoder #(.DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [32:0] exp_q[$];
   logic [63:0] imm_q[$];
   logic [2:0]  fmt_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          exp_enc  = 0;
   int          exp_err  = 0;
   bit          rand_rdy = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [32:0] model(input logic [2:0] f, input logic [63:0] imm,
                                         input logic [4:0] rt, input logic [4:0] rn);
      longint s;
      s = $signed(imm);
      case (f)
         3'd0, 3'd1:
            if (s >= -256 && s <= 255)
               return {1'b0, (f == 3'd0) ? 11'h7C2 : 11'h7C0, imm[8:0], 2'b00, rn, rt};
         3'd2, 3'd3:
            if (imm[1:0] == 2'b00 && s >= -1048576 && s <= 1048572)
               return {1'b0, (f == 3'd2) ? 8'hB4 : 8'hB5, imm[20:2], rt};
         3'd4, 3'd5:
            if (s >= 0 && s <= 4095)
               return {1'b0, (f == 3'd4) ? 10'h244 : 10'h344, imm[11:0], rn, rt};
         default: ;
      endcase
      return {1'b1, 32'h0};
   endfunction

   function automatic logic [63:0] decode(input logic [2:0] f, input logic [31:0] w);
      case (f)
         3'd0, 3'd1: return {{55{w[20]}}, w[20:12]};
         3'd2, 3'd3: return {{43{w[23]}}, w[23:5], 2'b00};
         3'd4, 3'd5: return {52'd0, w[21:10]};
         default:    return 64'd0;
      endcase
   endfunction

   // driver: called at posedge+1, returns at posedge+1 after the accepting edge
   task automatic send(input logic [2:0] f, input logic [63:0] imm, input logic [4:0] rt,
                       input logic [4:0] rn, input logic [32:0] exp);
      bit done;
      done = 0;
      bus.in_valid = 1'b1;
      bus.in_fmt   = f;
      bus.in_imm   = imm;
      bus.in_rt    = rt;
      bus.in_rn    = rn;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            exp_q.push_back(exp);
            imm_q.push_back(imm);
            fmt_q.push_back(f);
            if (exp[32]) begin
               if (exp_err < 65535) exp_err++;
            end else begin
               exp_enc = (exp_enc + 1) % 65536;
            end
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      if (!done) check("send_timeout", 64'(done), 64'(1));
   endtask

   task automatic send_model(input logic [2:0] f, input logic [63:0] imm,
                             input logic [4:0] rt, input logic [4:0] rn);
      send(f, imm, rt, rn, model(f, imm, rt, rn));
   endtask

   task automatic drain();
      for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
      #1;
      check("drain", 64'(exp_q.size()), 64'(0));
   endtask

   // scoreboard: the pop happens on the next posedge after this sample
   always @(negedge clk) begin
      logic [32:0] e;
      logic [63:0] im;
      logic [2:0]  f;
      if (!reset) begin
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_output", 64'(1), 64'(0));
            end else begin
               e  = exp_q.pop_front();
               im = imm_q.pop_front();
               f  = fmt_q.pop_front();
               check("out_instr", 64'(bus.out_instr), 64'(e[31:0]));
               check("out_err", 64'(bus.out_err), 64'(e[32]));
               if (!e[32]) check("decoded_imm", decode(f, bus.out_instr), im);
            end
         end else if (!bus.out_valid) begin
            check("empty_output", 64'({bus.out_err, bus.out_instr}), 64'(0));
         end
      end
   end

   initial begin
      logic [31:0] hold;
      longint      v;
      logic [2:0]  f;

      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_fmt    = 3'd0;
      bus.in_imm    = 64'd0;
      bus.in_rt     = 5'd0;
      bus.in_rn     = 5'd0;
      bus.out_ready = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 64'(bus.in_ready), 64'(0));
      check("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("rst_err_count", 64'(bus.err_count), 64'(0));
      check("rst_enc_count", 64'(bus.enc_count), 64'(0));
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_reset", 64'(bus.in_ready), 64'(1));

      // directed encodings
      bus.out_ready = 1'b1;
      check("empty_before_accept", 64'(bus.out_valid), 64'(0));
      send(3'b000, -64'sd8, 5'd1, 5'd2, {1'b0, 32'hF85F_8041});
      check("latency_valid", 64'(bus.out_valid), 64'(1));
      check("enc_count_ldur", 64'(bus.enc_count), 64'(1));
      send(3'b011, -64'sd4, 5'd3, 5'd0, {1'b0, 32'hB5FF_FFE3});
      send(3'b010, 64'd6, 5'd3, 5'd0, {1'b1, 32'h0});
      check("err_count_cbz", 64'(bus.err_count), 64'(1));
      send(3'b100, 64'd4095, 5'd0, 5'd0, {1'b0, 32'h913F_FC00});
      send(3'b100, 64'd4096, 5'd0, 5'd0, {1'b1, 32'h0});
      send(3'b111, 64'd0, 5'd0, 5'd0, {1'b1, 32'h0});
      send(3'b101, -64'sd1, 5'd4, 5'd4, {1'b1, 32'h0});
      drain();
      check("enc_count_dir", 64'(bus.enc_count), 64'(3));
      check("err_count_dir", 64'(bus.err_count), 64'(4));

      // full boundary: DEPTH accepts, one extra held
      bus.out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) send_model(3'b001, 64'(i * 8), 5'(i + 1), 5'(i));
      check("full_in_ready", 64'(bus.in_ready), 64'(0));
      hold = bus.out_instr;
      fork
         send_model(3'b001, -64'sd256, 5'd9, 5'd9);
         begin
            repeat (3) @(posedge clk);
            #1;
            check("held_in_ready", 64'(bus.in_ready), 64'(0));
            check("held_not_taken", 64'(exp_q.size()), 64'(DEPTH));
            check("head_stable", 64'(bus.out_instr), 64'(hold));
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            check("ready_after_pop", 64'(bus.in_ready), 64'(1));
         end
      join
      drain();
      check("enc_count_full", 64'(bus.enc_count), 64'(exp_enc));

      // reset with entries queued
      bus.out_ready = 1'b0;
      send_model(3'b100, 64'd7, 5'd1, 5'd1);
      send_model(3'b100, 64'd8, 5'd2, 5'd2);
      reset = 1'b1;
      #1;
      check("mid_rst_out_valid", 64'(bus.out_valid), 64'(0));
      check("mid_rst_in_ready", 64'(bus.in_ready), 64'(0));
      check("mid_rst_enc_count", 64'(bus.enc_count), 64'(0));
      check("mid_rst_err_count", 64'(bus.err_count), 64'(0));
      exp_q.delete();
      imm_q.delete();
      fmt_q.delete();
      exp_enc = 0;
      exp_err = 0;
      #3;
      reset = 1'b0;
      @(posedge clk);
      #1;
      check("mid_rst_ready_back", 64'(bus.in_ready), 64'(1));
      bus.out_ready = 1'b1;
      send_model(3'b101, 64'd100, 5'd6, 5'd5);
      drain();
      check("mid_rst_enc_after", 64'(bus.enc_count), 64'(1));

      // random sweep with random back-pressure
      rand_rdy = 1;
      fork
         while (rand_rdy) begin
            @(posedge clk);
            #1;
            bus.out_ready = 1'($urandom_range(0, 1));
         end
         begin
            for (int n = 0; n < 60; n++) begin
               f = 3'($urandom_range(0, 7));
               case (f)
                  3'd0, 3'd1: v = longint'($urandom_range(0, 640)) - 320;
                  3'd2, 3'd3: begin
                     v = longint'($urandom_range(0, 2300000)) - 1150000;
                     if ($urandom_range(0, 3) != 0) v = v & ~longint'(3);
                  end
                  3'd4, 3'd5: v = longint'($urandom_range(0, 4400)) - 200;
                  default:    v = longint'($urandom_range(0, 100));
               endcase
               if ($urandom_range(0, 15) == 0) v = {$urandom, $urandom};
               send_model(f, 64'(v), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
            end
            rand_rdy = 0;
         end
      join
      bus.out_ready = 1'b1;
      drain();
      check("enc_count_final", 64'(bus.enc_count), 64'(exp_enc));
      check("err_count_final", 64'(bus.err_count), 64'(exp_err));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
